// File: rtl/mul_issue_pkg.sv
// Shared definitions for the multiplier issue controller.
//   - state_t     : controller FSM encoding (also exported on dbg_state)
//   - MUL_WIDTH   : default operand width
//   - MAX_SETTLE  : largest settle interval the 8-bit timer can express
//   - CNT_W       : settle timer width
package mul_issue_pkg;

  localparam int MUL_WIDTH  = 32;
  localparam int MAX_SETTLE = 255;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Operand-in / result-out handshake bundle for mul_issue_ctrl.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The source holds valid and its payload
// stable until that edge; ready may change freely.
//
//   in_valid/in_ready/in_a/in_b         : operand pair channel
//   out_valid/out_ready/out_data/out_hi : result beat channel (low, then high)
//
// Modports: slave = the controller, master = the environment driving it.
interface mul_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_hi;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_hi
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_hi
  );
endinterface

// File: rtl/mul_settle_timer.sv
// Loadable down-counter timing the multiplier settle interval.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one; holds at zero
//   o_zero     : count is zero
module mul_settle_timer
  import mul_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequential front/back-end for an external combinational array multiplier.
// Latches an operand pair, holds it on mul_a/mul_b for SETTLE_CYCLES clocks,
// samples mul_c and returns the product as a low beat then a high beat.
//
// Parameters: WIDTH (operand width), SETTLE_CYCLES (1..255).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : operand/result handshakes (mul_issue_ctrl_if.slave)
//   mul_a/mul_b : held operands to the multiplier
//   mul_c       : multiplier product
//   busy        : controller is not IDLE
//   dbg_state   : current FSM state
// Optional: MUL_ZERO_SKIP_EN - a zero operand skips the settle wait and
// returns a zero product directly.
module mul_issue_ctrl
  import mul_issue_pkg::*;
#(
  parameter int WIDTH         = MUL_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  mul_issue_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_c,
  output logic               busy,
  output state_t             dbg_state
);

  // Counter starts at SETTLE_CYCLES-1 so it reads zero on the edge
  // SETTLE_CYCLES after acceptance.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_prod;
  logic               w_accept;
  logic               w_zero_op;
  logic               w_timer_zero;

  assign w_accept = bus.in_valid && (r_state == IDLE);

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero_op = (bus.in_a == '0) || (bus.in_b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  mul_settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_en       (r_state == SETTLE),
    .o_zero     (w_timer_zero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_zero_op ? SEND_LO : SETTLE;
      SETTLE:  if (w_timer_zero) w_next = SEND_LO;
      SEND_LO: if (bus.out_ready) w_next = SEND_HI;
      SEND_HI: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand and product datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_prod  <= '0;
    end else begin
      if (w_accept) begin
        r_mul_a <= bus.in_a;
        r_mul_b <= bus.in_b;
      end
      if (w_accept && w_zero_op) begin
        r_prod <= '0;
      end else if ((r_state == SETTLE) && w_timer_zero) begin
        r_prod <= mul_c;
      end
    end
  end

  // Output logic. in_ready is masked by rst so nothing is offered while
  // the block is held in reset.
  always_comb begin
    bus.in_ready  = (r_state == IDLE) && !rst;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_hi    = 1'b0;
    case (r_state)
      SEND_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_prod[WIDTH-1:0];
      end
      SEND_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_prod[2*WIDTH-1:WIDTH];
        bus.out_hi    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;
  import mul_issue_pkg::*;

  localparam int W = 32;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT with SETTLE_CYCLES=4 ----------------
  mul_issue_ctrl_if #(.WIDTH(W)) bus ();
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_c;
  logic           busy;
  state_t         dbg_state;

  // Behavioural stand-in for the external array multiplier.
  assign mul_c = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  mul_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT with SETTLE_CYCLES=1 ----------------
  mul_issue_ctrl_if #(.WIDTH(W)) bus1 ();
  logic [W-1:0]   mul1_a, mul1_b;
  logic [2*W-1:0] mul1_c;
  logic           busy1;
  state_t         dbg_state1;

  assign mul1_c = {{W{1'b0}}, mul1_a} * {{W{1'b0}}, mul1_b};

  mul_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .mul_a(mul1_a), .mul_b(mul1_b), .mul_c(mul1_c),
    .busy(busy1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    bit           zero_op;
    int           stall;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  // Called at a negedge. Presents a pair, waits (bounded) for in_ready,
  // lets the acceptance edge pass and returns at the following negedge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mul_a_latched", 64'(mul_a), 64'(a));
    check("mul_b_latched", 64'(mul_b), 64'(b));
  endtask

  // Called at the negedge after acceptance edge E0. Checks when out_valid
  // rises (in cycles after E0), stalls the low beat, then checks both beats.
  task automatic wait_beats(input logic [W-1:0] lo, input logic [W-1:0] hi,
                            input int lat, input int stall);
    int k;
    logic [W-1:0] a_hold;
    a_hold = mul_a;
    bus.out_ready = (stall == 0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      check("in_ready_while_busy", 64'(bus.in_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(lat));
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_data",  64'(bus.out_data), 64'(lo));
      check("stall_hi",    64'(bus.out_hi), 64'd0);
      @(posedge clk); @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("lo_valid", 64'(bus.out_valid), 64'd1);
    check("lo_data",  64'(bus.out_data), 64'(lo));
    check("lo_flag",  64'(bus.out_hi), 64'd0);
    @(posedge clk); @(negedge clk);
    check("hi_valid", 64'(bus.out_valid), 64'd1);
    check("hi_data",  64'(bus.out_data), 64'(hi));
    check("hi_flag",  64'(bus.out_hi), 64'd1);
    check("operand_stable", 64'(mul_a), 64'(a_hold));
    @(posedge clk); @(negedge clk);
    check("done_valid", 64'(bus.out_valid), 64'd0);
    check("done_data",  64'(bus.out_data), 64'd0);
    check("done_ready", 64'(bus.in_ready), 64'd1);
    check("done_busy",  64'(busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int seen;
    bus.in_valid  = 1'b0; bus.in_a  = '0; bus.in_b  = '0; bus.out_ready  = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b1;

    vecs[0] = '{32'h0000000F, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h0000000E, 1'b0, 0};
    vecs[1] = '{32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 2};
    vecs[3] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 0};
    vecs[4] = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000, 1'b0, 1};
    vecs[5] = '{32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 32'h00000000, 1'b0, 0};
    vecs[6] = '{32'h0000ABCD, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[7] = '{32'h00000010, 32'hFFFFFFFE, 32'hFFFFFFE0, 32'h0000000F, 1'b0, 3};

    // Reset state
    #2;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data",  64'(bus.out_data), 64'd0);
    check("rst_hi",    64'(bus.out_hi), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      lat = S;
`ifdef MUL_ZERO_SKIP_EN
      if (vecs[i].zero_op) lat = 0;
`endif
      accept(vecs[i].a, vecs[i].b);
      wait_beats(vecs[i].lo, vecs[i].hi, lat, vecs[i].stall);
    end

    // Back-to-back: second pair presented while busy
    accept(32'h0000000F, 32'hFFFFFFFF);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h00000010;
    bus.in_b     = 32'hFFFFFFFE;
    check("b2b_not_ready", 64'(bus.in_ready), 64'd0);
    check("b2b_hold_a", 64'(mul_a), 64'h0F);
    wait_beats(32'hFFFFFFF1, 32'h0000000E, S, 0);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_second_a", 64'(mul_a), 64'h10);
    check("b2b_second_b", 64'(mul_b), 64'hFFFFFFFE);
    wait_beats(32'hFFFFFFE0, 32'h0000000F, S, 0);

    // Reset in the middle of SETTLE
    accept(32'h00000003, 32'h00000005);
    @(posedge clk); @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_data",  64'(bus.out_data), 64'd0);
    check("midrst_busy",  64'(busy), 64'd0);
    check("midrst_mul_a", 64'(mul_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_beat", 64'(seen), 64'd0);

    // SETTLE_CYCLES=1 instance: capture on first edge after acceptance
    bus1.in_valid = 1'b1;
    bus1.in_a     = 32'hFFFFFFFF;
    bus1.in_b     = 32'hFFFFFFFF;
    check("s1_ready", 64'(bus1.in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    bus1.in_valid = 1'b0;
    check("s1_settle_valid", 64'(bus1.out_valid), 64'd0);
    check("s1_settle_busy",  64'(busy1), 64'd1);
    @(posedge clk); @(negedge clk);
    check("s1_lo_valid", 64'(bus1.out_valid), 64'd1);
    check("s1_lo_data",  64'(bus1.out_data), 64'h00000001);
    check("s1_lo_flag",  64'(bus1.out_hi), 64'd0);
    @(posedge clk); @(negedge clk);
    check("s1_hi_data",  64'(bus1.out_data), 64'hFFFFFFFE);
    check("s1_hi_flag",  64'(bus1.out_hi), 64'd1);
    @(posedge clk); @(negedge clk);
    check("s1_done_valid", 64'(bus1.out_valid), 64'd0);
    check("s1_done_ready", 64'(bus1.in_ready), 64'd1);
    check("s1_done_state", 64'(dbg_state1), 64'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequential front/back-end for the combinational 32x32 array multiplier (array32) in the bitwise ALU path.
- Accepts an operand pair over a valid/ready handshake and drives the held operands into the multiplier.
- Waits a fixed settle interval for the multiplier's ripple to resolve, then captures the 64-bit product.
- Returns the product as two 32-bit beats (low, then high) over a valid/ready output handshake.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- SETTLE_CYCLES, 4, clock cycles the operands are held before the product is sampled; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- mul_a  out  WIDTH  registered multiplicand to array32 .a.
- mul_b  out  WIDTH  registered multiplier to array32 .b.
- mul_c  in  2*WIDTH  product from array32 .c.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  result beat.
- out_hi  out  1  0 = low word beat, 1 = high word beat.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; mul_a=mul_b=0; product register=0; counter=0.
  - in_ready=1 once rst deasserts.
  - out_valid=0, out_data=0, out_hi=0, busy=0.
- Reset mid-operation discards the operation with no partial output. Any beat in flight is dropped.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b into mul_a/mul_b, load counter=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: in_ready=0. The counter decrements each cycle. At the edge where counter==0, capture mul_c into the product register and go to SEND_LO.
  - SEND_LO: out_valid=1, out_data=prod[WIDTH-1:0], out_hi=0. On out_ready go to SEND_HI, otherwise hold.
  - SEND_HI: out_valid=1, out_data=prod[2*WIDTH-1:WIDTH], out_hi=1. On out_ready go to IDLE, otherwise hold.
- Latency, with acceptance at edge E0:
  - Product is captured at edge E0+SETTLE_CYCLES.
  - out_valid is high from that edge.
  - With out_ready tied 1, the low beat transfers at E0+S+1 and the high beat at E0+S+2.
  - in_ready is high after E0+S+2.
- Operand and output stability:
  - mul_a/mul_b change only on acceptance and are stable through SETTLE and both send states.
  - out_data and out_hi are stable while out_valid=1 and out_ready=0.
  - out_data=0 when out_valid=0.
- No overlap: in_ready=0 whenever busy=1. An in_valid asserted while busy is ignored and must be held by upstream.
- Arithmetic: unsigned; the product is exactly mul_c as sampled with no truncation. For SETTLE_CYCLES=1 the capture occurs on the first edge after acceptance.

Optional Feature:
- MUL_ZERO_SKIP_EN defined:
  - On acceptance, if in_a==0 or in_b==0, the product register is loaded with 0 at E0 and the state goes directly to SEND_LO, bypassing SETTLE.
  - out_valid is high from E0.
- MUL_ZERO_SKIP_EN undefined: every operation passes through SETTLE regardless of operand values.

Decomposition:
- Shared package mul_issue_pkg holds:
  - State encoding: IDLE=2'd0, SETTLE=2'd1, SEND_LO=2'd2, SEND_HI=2'd3.
  - MUL_WIDTH=32.
  - MAX_SETTLE=255.
  - Counter width of 8.
- Sub-module mul_settle_timer: loadable 8-bit down-counter with load, enable and a zero flag, instantiated once.
- array32 stays external and is connected by the parent via mul_a/mul_b/mul_c.

Test Plan:
- Basic product: accept a=0x0000000F, b=0xFFFFFFFF with out_ready=1, SETTLE_CYCLES=4.
  - Low beat 0xFFFFFFF1 (out_hi=0) at E0+5, high beat 0x0000000E (out_hi=1) at E0+6.
  - in_ready returns to 1 after that edge.
- Back-to-back: second pair a=0x10, b=0xFFFFFFFE presented during busy.
  - Not accepted until IDLE; then beats 0xFFFFFFE0, 0x0000000F.
- Output stall: out_ready=0 for 3 cycles in SEND_LO, then 1.
  - out_data is held at the low word and out_hi=0 throughout; no beat is lost or duplicated.
- Reset mid-SETTLE: assert rst two cycles after acceptance.
  - All outputs go to 0 immediately; after release in_ready=1 and no result beat appears.
- Zero operand a=0, b=0x12345678:
  - Without MUL_ZERO_SKIP_EN: beats 0, 0 after the full settle latency.
  - With MUL_ZERO_SKIP_EN: low beat at E0+1.
- SETTLE_CYCLES=1 build: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Beats 0x00000001, then 0xFFFFFFFE.
